// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences fetch/decode/execute around taken-branch
// flushes, memory waits and load-use stalls, and counts lost cycles.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned LOAD_STALL   = 1,
   parameter int unsigned RA_W         = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_taken,
   input  logic            ex_ld,
   input  logic            ex_rd_en,
   input  logic [RA_W-1:0] ex_rd_addr,
   input  logic [RA_W-1:0] id_rs_addr,
   input  logic [RA_W-1:0] id_rt_addr,
   input  logic            id_rs_use,
   input  logic            id_rt_use,
   input  logic            mem_req,
   input  logic            mem_ack,
   output logic            pc_en,
   output logic            if_id_en,
   output logic            id_ex_en,
   output logic            nop,
   output logic            flush_out,
   output logic [1:0]      state,
   output logic [15:0]     stall_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      FLUSH   = 2'b01,
      LDSTALL = 2'b10,
      MEMWAIT = 2'b11
   } state_t;

   localparam int unsigned CNT_MAX = (FLUSH_CYCLES > LOAD_STALL) ? FLUSH_CYCLES : LOAD_STALL;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   // Counter holds the bubble cycles still owed after the current one.
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] LD_LOAD    = CNT_W'((LOAD_STALL >= 2) ? LOAD_STALL - 2 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz;

   assign hz = ex_ld & ex_rd_en & (ex_rd_addr != '0) &
               ((id_rs_use & (id_rs_addr == ex_rd_addr)) |
                (id_rt_use & (id_rt_addr == ex_rd_addr)));

   // Next-state and stage-control decode; reset forces a held, bubbling pipe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      nop       = 1'b0;
      flush_out = 1'b0;
      unique case (state_q)
         RUN, MEMWAIT: begin
            if (state_q == MEMWAIT && !mem_ack) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
            end else if (br_taken) begin
               flush_out = 1'b1;
               nop       = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end else begin
                  state_d = RUN;
               end
            end else if (state_q == RUN && mem_req && !mem_ack) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               state_d  = MEMWAIT;
            end else if (state_q == RUN && mem_req) begin
               state_d = RUN;
            end else if (hz) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               nop      = 1'b1;
               if (LOAD_STALL > 1) begin
                  state_d = LDSTALL;
                  cnt_d   = LD_LOAD;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            flush_out = 1'b1;
            nop       = 1'b1;
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         LDSTALL: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            nop      = 1'b1;
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = RUN;
      endcase
      if (rst) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         nop       = 1'b1;
         flush_out = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Saturating count of cycles where fetch is held or a bubble is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((!pc_en || nop) && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, LOAD_STALL=1).
module tb_pipe_hazard_ctrl;
   localparam int unsigned RA_W = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            br_taken, ex_ld, ex_rd_en, id_rs_use, id_rt_use, mem_req, mem_ack;
   logic [RA_W-1:0] ex_rd_addr, id_rs_addr, id_rt_addr;
   logic            pc_en, if_id_en, id_ex_en, nop, flush_out;
   logic [1:0]      state;
   logic [15:0]     stall_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL(1), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst), .br_taken(br_taken), .ex_ld(ex_ld), .ex_rd_en(ex_rd_en),
      .ex_rd_addr(ex_rd_addr), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .nop(nop),
      .flush_out(flush_out), .state(state), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected vector order: {pc_en, if_id_en, id_ex_en, nop, flush_out, state[1:0]}
   task automatic chk_out(input string tag, input logic [6:0] exp);
      chk(tag, 32'({pc_en, if_id_en, id_ex_en, nop, flush_out, state}), 32'(exp));
   endtask

   task automatic idle();
      br_taken = 0; ex_ld = 0; ex_rd_en = 0; id_rs_use = 0; id_rt_use = 0;
      mem_req = 0; mem_ack = 0; ex_rd_addr = '0; id_rs_addr = '0; id_rt_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_ld(input logic [RA_W-1:0] rd, input logic rs_u, input logic [RA_W-1:0] rs,
                         input logic rt_u, input logic [RA_W-1:0] rt);
      ex_ld = 1; ex_rd_en = 1; ex_rd_addr = rd;
      id_rs_use = rs_u; id_rs_addr = rs; id_rt_use = rt_u; id_rt_addr = rt;
   endtask

   initial begin
      // Reset behaviour
      rst = 1'b1;
      idle();
      #1;
      chk_out("rst_outs_early", 7'b000_1_0_00);
      repeat (3) tick();
      chk_out("rst_outs", 7'b000_1_0_00);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk_out("post_rst_run", 7'b111_0_0_00);
      chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

      // Taken branch: two flush cycles, branch in FLUSH ignored
      do_reset();
      br_taken = 1; #1;
      chk_out("br_run", 7'b111_1_1_00);
      tick(); #1;
      chk_out("br_flush", 7'b111_1_1_01);
      tick(); br_taken = 0; #1;
      chk_out("br_back_run", 7'b111_0_0_00);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

      // Load-use hazards on Rt and Rs, plus non-hazard variants
      do_reset();
      set_ld(5'd5, 0, 5'd0, 1, 5'd5); #1;
      chk_out("ldu_rt", 7'b001_1_0_00);
      tick(); idle(); #1;
      chk_out("ldu_after", 7'b111_0_0_00);
      chk("ldu_stall_cnt", 32'(stall_cnt), 32'd1);
      set_ld(5'd0, 0, 5'd0, 1, 5'd0); #1;
      chk_out("ldu_r0", 7'b111_0_0_00);
      tick();
      chk("ldu_r0_stall_cnt", 32'(stall_cnt), 32'd1);
      set_ld(5'd7, 1, 5'd7, 0, 5'd3); #1;
      chk_out("ldu_rs", 7'b001_1_0_00);
      tick();
      set_ld(5'd7, 0, 5'd7, 1, 5'd3); #1;
      chk_out("ldu_rs_unused", 7'b111_0_0_00);
      ex_rd_en = 0; id_rt_addr = 5'd7; #1;
      chk_out("ldu_no_rd_en", 7'b111_0_0_00);
      tick(); idle();

      // Memory wait: 4 cycles without ack, then ack
      do_reset();
      mem_req = 1; #1;
      chk_out("mw_enter", 7'b000_0_0_00);
      for (int i = 0; i < 3; i++) begin
         tick();
         br_taken = (i == 1);
         #1;
         chk_out($sformatf("mw_wait%0d", i), 7'b000_0_0_11);
      end
      tick(); br_taken = 0; mem_ack = 1; #1;
      chk_out("mw_ack", 7'b111_0_0_11);
      chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
      tick(); idle(); #1;
      chk_out("mw_done", 7'b111_0_0_00);
      chk("mw_done_stall_cnt", 32'(stall_cnt), 32'd4);

      // Ack cycle still honours a branch, then a load-use hazard
      do_reset();
      mem_req = 1; tick();
      mem_ack = 1; br_taken = 1; #1;
      chk_out("mw_ack_br", 7'b111_1_1_11);
      tick(); idle(); #1;
      chk_out("mw_ack_br_flush", 7'b111_1_1_01);
      tick(); #1;
      mem_req = 1; tick();
      mem_ack = 1; set_ld(5'd9, 1, 5'd9, 0, 5'd0); #1;
      chk_out("mw_ack_hz", 7'b001_1_0_11);
      tick(); idle(); #1;
      chk_out("mw_ack_hz_run", 7'b111_0_0_00);
      // In RUN, an acked memory access outranks the load-use hazard
      mem_req = 1; mem_ack = 1; set_ld(5'd9, 1, 5'd9, 0, 5'd0); #1;
      chk_out("run_memack_hz", 7'b111_0_0_00);
      tick(); idle();

      // Branch wins over memory request and hazard together
      do_reset();
      br_taken = 1; mem_req = 1; set_ld(5'd4, 1, 5'd4, 1, 5'd4); #1;
      chk_out("prio_all", 7'b111_1_1_00);
      tick(); idle(); #1;
      chk_out("prio_flush", 7'b111_1_1_01);

      // Async reset mid-MEMWAIT and mid-FLUSH
      do_reset();
      mem_req = 1; tick(); tick(); #1;
      chk_out("mid_mw", 7'b000_0_0_11);
      rst = 1; #1;
      chk_out("rst_mid_mw", 7'b000_1_0_00);
      chk("rst_mid_mw_cnt", 32'(stall_cnt), 32'd0);
      idle(); #2; rst = 0; tick(); #1;
      chk_out("rst_mid_mw_run", 7'b111_0_0_00);
      br_taken = 1; tick(); br_taken = 0; #1;
      chk_out("mid_flush", 7'b111_1_1_01);
      rst = 1; #1;
      chk_out("rst_mid_flush", 7'b000_1_0_00);
      chk("rst_mid_flush_cnt", 32'(stall_cnt), 32'd0);
      #2; rst = 0; tick(); #1;
      chk_out("rst_mid_flush_run", 7'b111_0_0_00);

      // Saturation of the stall counter
      do_reset();
      mem_req = 1;
      repeat (65534) tick();
      chk("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
      repeat (70000 - 65534) tick();
      chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
